sd_d_driver: RTL and testbench

- SD-card 4-bit DAT-line driver inside the SD transceiver. Transfers one 512-byte block (1024 nibbles) between the DAT[3:0] bus and a 1024x4 block buffer.
- Read: card -> buffer, with per-line CRC16 check.
- Write: buffer -> card, with per-line CRC16 generation and CRC-status/busy handling.
- Sequenced by the command-level controller through start/done handshakes.

---
 rtl/sd_d_driver_pkg.sv | 37 +++
 rtl/sd_crc16_serial.sv | 24 ++
 rtl/sd_d_driver.sv | 196 +++++++++++++++++++
 tb/tb_sd_d_driver.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_d_driver_pkg.sv
// Shared constants, state encoding and the serial CRC16 step for the SD DAT-line driver.
// Block length, bus symbols and the accepted-status token live here so the FSM and CRC agree.
package sd_d_driver_pkg;

  localparam int          BLOCK_LEN       = 1024;
  localparam int          ADDR_W          = 10;
  localparam int          CRC_LEN         = 16;
  localparam logic [15:0] CRC16_POLY      = 16'h1021;
  localparam logic        START_BIT       = 1'b0;
  localparam logic        END_BIT         = 1'b1;
  localparam logic [3:0]  BUS_START       = 4'h0;
  localparam logic [3:0]  BUS_IDLE        = 4'hF;
  localparam logic [2:0]  STATUS_ACCEPTED = 3'b010;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_START,
    ST_RD_DATA,
    ST_RD_CRC,
    ST_RD_END,
    ST_WR_START,
    ST_WR_DATA,
    ST_WR_CRC,
    ST_WR_END,
    ST_WR_STAT,
    ST_WR_BUSY,
    ST_DONE
  } state_t;

  // One bit of CRC16-CCITT, MSB-first shift register form.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sd_crc16_serial.sv
// Bit-serial CRC16-CCITT accumulator for one DAT line; synchronous clear wins over enable.
module sd_crc16_serial
  import sd_d_driver_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        enable,
  input  logic        data_bit,
  output logic [15:0] crc
);

  logic [15:0] crc_reg;

  always_ff @(posedge clk) begin
    if (clear) begin
      crc_reg <= '0;
    end else if (enable) begin
      crc_reg <= crc16_step(crc_reg, data_bit);
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/sd_d_driver.sv
// SD 4-bit DAT-line driver: moves one 1024-nibble block between the card bus and the block buffer,
// generating/checking per-line CRC16 and handling the write CRC-status token and busy phase.
module sd_d_driver
  import sd_d_driver_pkg::*;
(
  input  logic        iclk,
  input  logic        irst,
  input  logic [3:0]  idata_sd,
  output logic [3:0]  odata_sd,
  input  logic        istart_read,
  input  logic        istart_write,
  output logic [9:0]  oaddr,
  output logic [3:0]  owdata,
  output logic        owrite_en,
  input  logic [3:0]  irdata,
  output logic        ocrc_fail,
  output logic        odone
);

  localparam logic [ADDR_W-1:0] LAST_NIBBLE = ADDR_W'(BLOCK_LEN - 1);
  localparam logic [3:0]        LAST_CRC    = 4'(CRC_LEN - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              err_reg, err_next;
  logic              fail_reg, fail_next;
  logic              stat_seen_reg, stat_seen_next;
  logic [2:0]        token_reg, token_next;

  logic              start_accept;
  logic              crc_clear;
  logic              crc_enable;
  logic [3:0]        crc_din;
  logic [3:0]        crc_sel;
  logic [3:0]        crc_bit;
  logic [15:0]       crc_line [4];

  assign start_accept = (state_reg == ST_IDLE) && (istart_read || istart_write);
  assign crc_clear    = irst || start_accept;
  assign crc_enable   = (state_reg == ST_RD_DATA) || (state_reg == ST_WR_DATA);
  // On write the CRC must cover exactly what goes out on the bus, i.e. the buffer data.
  assign crc_din      = (state_reg == ST_WR_DATA) ? irdata : idata_sd;
  assign crc_sel      = LAST_CRC - cnt_reg[3:0];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_line
      sd_crc16_serial u_crc (
        .clk      (iclk),
        .clear    (crc_clear),
        .enable   (crc_enable),
        .data_bit (crc_din[gi]),
        .crc      (crc_line[gi])
      );
      assign crc_bit[gi] = crc_line[gi][crc_sel];
    end
  endgenerate

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      addr_reg      <= '0;
      err_reg       <= 1'b0;
      fail_reg      <= 1'b0;
      stat_seen_reg <= 1'b0;
      token_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      addr_reg      <= addr_next;
      err_reg       <= err_next;
      fail_reg      <= fail_next;
      stat_seen_reg <= stat_seen_next;
      token_reg     <= token_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    addr_next      = addr_reg;
    err_next       = err_reg;
    fail_next      = fail_reg;
    stat_seen_next = stat_seen_reg;
    token_next     = token_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (start_accept) begin
          state_next = istart_read ? ST_RD_START : ST_WR_START;
          cnt_next   = '0;
          addr_next  = '0;
          err_next   = 1'b0;
          fail_next  = 1'b0;
        end
      end
      ST_RD_START: begin
        if (idata_sd == BUS_START) state_next = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        addr_next = addr_reg + 1'b1;
        cnt_next  = cnt_reg + 1'b1;
        if (cnt_reg == LAST_NIBBLE) begin
          state_next = ST_RD_CRC;
          cnt_next   = '0;
          addr_next  = '0;
        end
      end
      ST_RD_CRC: begin
        if (idata_sd != crc_bit) err_next = 1'b1;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg[3:0] == LAST_CRC) begin
          state_next = ST_RD_END;
          cnt_next   = '0;
        end
      end
      ST_RD_END: begin
        if (idata_sd != BUS_IDLE) err_next = 1'b1;
        state_next = ST_DONE;
      end
      ST_WR_START: begin
        // Address 0 was presented here, so its data lands on the first WR_DATA cycle.
        addr_next  = addr_reg + 1'b1;
        state_next = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        addr_next = addr_reg + 1'b1;
        cnt_next  = cnt_reg + 1'b1;
        if (cnt_reg == LAST_NIBBLE) begin
          state_next = ST_WR_CRC;
          cnt_next   = '0;
          addr_next  = '0;
        end
      end
      ST_WR_CRC: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg[3:0] == LAST_CRC) begin
          state_next = ST_WR_END;
          cnt_next   = '0;
        end
      end
      ST_WR_END: begin
        state_next     = ST_WR_STAT;
        stat_seen_next = 1'b0;
        cnt_next       = '0;
      end
      ST_WR_STAT: begin
        if (!stat_seen_reg) begin
          if (idata_sd[0] == START_BIT) stat_seen_next = 1'b1;
        end else if (cnt_reg[1:0] != 2'd3) begin
          token_next = {token_reg[1:0], idata_sd[0]};
          cnt_next   = cnt_reg + 1'b1;
        end else begin
          // This cycle carries the end bit; the token is complete.
          if (token_reg != STATUS_ACCEPTED) err_next = 1'b1;
          state_next = ST_WR_BUSY;
          cnt_next   = '0;
        end
      end
      ST_WR_BUSY: begin
        if (idata_sd[0] == END_BIT) state_next = ST_DONE;
      end
      ST_DONE: begin
        fail_next  = err_reg;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    odata_sd  = BUS_IDLE;
    owdata    = 4'h0;
    owrite_en = 1'b0;
    odone     = 1'b0;
    ocrc_fail = fail_reg;
    unique case (state_reg)
      ST_RD_DATA: begin
        owdata    = idata_sd;
        owrite_en = 1'b1;
      end
      ST_WR_START: odata_sd = BUS_START;
      ST_WR_DATA:  odata_sd = irdata;
      ST_WR_CRC:   odata_sd = crc_bit;
      ST_DONE: begin
        odone     = 1'b1;
        ocrc_fail = err_reg;
      end
      default: ;
    endcase
  end

  assign oaddr = addr_reg;

endmodule

// File: tb/tb_sd_d_driver.sv
// Scoreboard bench for sd_d_driver: stimulus plays card and controller, a monitor checks
// buffer writes, the driven DAT stream, done/crc_fail and output snapshots against queues.
module tb_sd_d_driver;

  logic       iclk = 1'b0;
  logic       irst;
  logic [3:0] idata_sd;
  logic [3:0] odata_sd;
  logic       istart_read;
  logic       istart_write;
  logic [9:0] oaddr;
  logic [3:0] owdata;
  logic       owrite_en;
  logic [3:0] irdata;
  logic       ocrc_fail;
  logic       odone;

  sd_d_driver dut (
    .iclk         (iclk),
    .irst         (irst),
    .idata_sd     (idata_sd),
    .odata_sd     (odata_sd),
    .istart_read  (istart_read),
    .istart_write (istart_write),
    .oaddr        (oaddr),
    .owdata       (owdata),
    .owrite_en    (owrite_en),
    .irdata       (irdata),
    .ocrc_fail    (ocrc_fail),
    .odone        (odone)
  );

  always #5 iclk = ~iclk;

  // Block buffer model: registered read, one clock of latency.
  logic [3:0] mem [1024];
  always @(posedge iclk) irdata <= mem[oaddr];

  typedef struct {
    string       name;
    logic [20:0] v;
  } snap_t;

  logic [13:0] wr_q [$];
  logic        done_q [$];
  logic [3:0]  dat_q [$];
  snap_t       snap_q [$];

  int  compared = 0;
  int  mismatched = 0;
  int  timeout_evt = 0;
  bit  mon_en = 1'b0;
  bit  end_req = 1'b0;
  bit  end_ack = 1'b0;

  function automatic logic [3:0] pat(input bit inv, input int n);
    return inv ? ~4'(n) : 4'(n);
  endfunction

  // Golden CRC as the remainder of the zero-augmented line bitstream divided by 0x11021.
  function automatic logic [15:0] crc_model(input bit inv, input int line);
    logic [16:0] rem;
    logic [3:0]  v;
    logic        b;
    rem = '0;
    for (int n = 0; n < 1024 + 16; n++) begin
      v   = pat(inv, n);
      b   = (n < 1024) ? v[line] : 1'b0;
      rem = {rem[15:0], b};
      if (rem[16]) rem = rem ^ 17'h11021;
    end
    return rem[15:0];
  endfunction

  function automatic logic [20:0] idle_snap(input logic fail);
    return {4'hF, 10'd0, 4'h0, 1'b0, fail, 1'b0};
  endfunction

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic push_snap(input string name, input logic [20:0] v);
    snap_t s;
    s.name = name;
    s.v    = v;
    snap_q.push_back(s);
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (done_q.size() != 0 && g < 100) begin
      tick();
      g++;
    end
    if (done_q.size() != 0) timeout_evt++;
  endtask

  task automatic run_read(input bit flip, input int abort_at);
    logic [15:0] crc [4];
    logic [3:0]  v;
    int          last;
    for (int i = 0; i < 4; i++) crc[i] = crc_model(1'b0, i);
    last = (abort_at >= 0) ? abort_at : 1023;
    for (int n = 0; n <= last; n++) wr_q.push_back({10'(n), pat(1'b0, n)});
    if (abort_at < 0) done_q.push_back(flip);
    $display("read transfer: crc_flip=%0d abort_at=%0d", flip, abort_at);
    istart_read = 1'b1;
    tick();
    istart_read = 1'b0;
    idata_sd    = 4'hF;
    repeat (5) tick();
    idata_sd = 4'h0;
    tick();
    for (int n = 0; n < 1024; n++) begin
      idata_sd = pat(1'b0, n);
      if (n == abort_at) begin
        irst = 1'b1;
        tick();
        irst     = 1'b0;
        idata_sd = 4'hF;
        push_snap("abort_reset", idle_snap(1'b0));
        tick();
        return;
      end
      tick();
    end
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 4; i++) v[i] = crc[i][15-k];
      if (flip && k == 2) v[0] = ~v[0];
      idata_sd = v;
      tick();
    end
    idata_sd = 4'hF;
    tick();
    wait_done();
    push_snap("read_after_done", idle_snap(flip));
    tick();
  endtask

  task automatic run_write(input logic [2:0] status, input bit exp_fail);
    logic [15:0] crc [4];
    logic [3:0]  v;
    int          g;
    for (int i = 0; i < 4; i++) crc[i] = crc_model(1'b1, i);
    dat_q.push_back(4'h0);
    for (int n = 0; n < 1024; n++) dat_q.push_back(pat(1'b1, n));
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 4; i++) v[i] = crc[i][15-k];
      dat_q.push_back(v);
    end
    dat_q.push_back(4'hF);
    done_q.push_back(exp_fail);
    $display("write transfer: status=%b expect_crc_fail=%0d", status, exp_fail);
    istart_write = 1'b1;
    tick();
    istart_write = 1'b0;
    idata_sd     = 4'hF;
    g = 0;
    while (odata_sd != 4'h0 && g < 20) begin
      tick();
      g++;
    end
    if (odata_sd != 4'h0) timeout_evt++;
    repeat (1045) tick();
    idata_sd = 4'hE;
    tick();
    for (int b = 2; b >= 0; b--) begin
      idata_sd = {3'b111, status[b]};
      tick();
    end
    idata_sd = 4'hF;
    tick();
    idata_sd = 4'hE;
    repeat (20) tick();
    idata_sd = 4'hF;
    wait_done();
    push_snap("write_after_done", idle_snap(exp_fail));
    tick();
  endtask

  // Monitor / scoreboard: the only process that compares and counts.
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name, input logic [31:0] act);
    compared++;
    mismatched++;
    $display("FAIL %s: got %h expected nothing", name, act);
  endtask

  initial begin : monitor
    bit          cap_active;
    int          cap_idx;
    int          tmo_seen;
    logic [13:0] we;
    logic [3:0]  d;
    snap_t       s;
    cap_active = 1'b0;
    cap_idx    = 0;
    tmo_seen   = 0;
    forever begin
      @(negedge iclk);
      if (mon_en) begin
        if (owrite_en === 1'b1) begin
          if (wr_q.size() == 0) fail_evt("unexpected_write", {18'd0, oaddr, owdata});
          else begin
            we = wr_q.pop_front();
            check("buffer_write", {18'd0, oaddr, owdata}, {18'd0, we});
          end
        end
        if (odone === 1'b1) begin
          if (done_q.size() == 0) fail_evt("unexpected_done", {31'd0, ocrc_fail});
          else check("done_crc_fail", {31'd0, ocrc_fail}, {31'd0, done_q.pop_front()});
        end
        if (!cap_active && dat_q.size() != 0 && odata_sd === 4'h0) begin
          cap_active = 1'b1;
          cap_idx    = 0;
        end
        if (cap_active) begin
          d = dat_q.pop_front();
          check($sformatf("dat_out_%0d", cap_idx), {28'd0, odata_sd}, {28'd0, d});
          cap_idx++;
          if (dat_q.size() == 0) cap_active = 1'b0;
        end
        if (snap_q.size() != 0) begin
          s = snap_q.pop_front();
          check(s.name, {11'd0, odata_sd, oaddr, owdata, owrite_en, ocrc_fail, odone}, {11'd0, s.v});
        end
        if (timeout_evt != tmo_seen) begin
          fail_evt("timeout", timeout_evt);
          tmo_seen = timeout_evt;
        end
        if (end_req && !end_ack) begin
          check("wr_q_drained", wr_q.size(), 0);
          check("done_q_drained", done_q.size(), 0);
          check("dat_q_drained", dat_q.size(), 0);
          check("snap_q_drained", snap_q.size(), 0);
          end_ack = 1'b1;
        end
      end
    end
  end

  initial begin : stimulus
    int g;
    for (int n = 0; n < 1024; n++) mem[n] = pat(1'b1, n);
    irst         = 1'b1;
    idata_sd     = 4'hF;
    istart_read  = 1'b0;
    istart_write = 1'b0;
    tick();
    irst   = 1'b0;
    mon_en = 1'b1;
    $display("reset: check reset values");
    push_snap("reset_values", idle_snap(1'b0));
    repeat (100) tick();
    $display("idle: 100 cycles");
    push_snap("idle_after_100", idle_snap(1'b0));
    tick();

    run_read(1'b0, -1);
    run_read(1'b1, -1);
    run_write(3'b010, 1'b0);
    run_write(3'b101, 1'b1);
    run_read(1'b0, 500);
    run_read(1'b0, -1);

    end_req = 1'b1;
    g = 0;
    while (!end_ack && g < 10) begin
      tick();
      g++;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
